// File: rtl/nn_seq_pkg.sv
// Shared types for the NN frame sequencer: FSM states, result entry layout
// and the batch-size clamp.
package nn_seq_pkg;

    localparam int MAX_IMAGES = 16;
    localparam int OUT_DATA   = 10;
    localparam int IMG_W      = $clog2(MAX_IMAGES + 1);
    localparam int OUT_W      = $clog2(OUT_DATA);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FETCH,
        WAIT_RES,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [IMG_W-1:0] index;
        logic [OUT_W-1:0] digit;
        logic             timeout;
    } res_entry_t;

    // A zero or oversized request means "a full batch".
    function automatic logic [31:0] clamp_count(input logic [31:0] cfg,
                                                input logic [31:0] max_n);
        return ((cfg == 32'd0) || (cfg > max_n)) ? max_n : cfg;
    endfunction

endpackage

// File: rtl/nn_result_fifo.sv
// First-word-fall-through result FIFO; head visible the cycle after push.
// Writer must not push when full unless the head is popped the same cycle.
module nn_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             full_o,
    output logic             pop_vld_o,
    input  logic             pop_rdy_i,
    output logic [WIDTH-1:0] pop_dat_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             pop;

    assign pop       = pop_vld_o && pop_rdy_i;
    assign pop_vld_o = (wr_q != rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // Gated so the head reads as zero whenever nothing is stored.
    assign pop_dat_o = pop_vld_o ? mem_q[rd_q[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_vld_i) wr_q <= wr_q + 1'b1;
            if (pop)        rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/nn_frame_sequencer.sv
// Streams a batch of images from pixel memory into the NN core and queues one result per image.
// Pixel path has 1-cycle latency; fetching stalls in ARM until a result slot is free.
module nn_frame_sequencer
    import nn_seq_pkg::*;
#(
    parameter int dataWidth      = 16,
    parameter int outData        = 10,
    parameter int outWidth       = $clog2(outData),
    parameter int pixelsPerImage = 784,
    parameter int maxImages      = 16,
    parameter int imgWidth       = $clog2(maxImages + 1),
    parameter int resDepth       = 4,
    parameter int timeoutCycles  = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [imgWidth-1:0]  cfg_num_images,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len,
    output logic                 mem_ren,
    input  logic                 mem_valid,
    input  logic [dataWidth-1:0] mem_data,
    input  logic                 mem_last,
    output logic                 net_valid,
    output logic [dataWidth-1:0] net_data,
    input  logic                 net_out_valid,
    input  logic [outWidth-1:0]  net_out_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [outWidth-1:0]  res_digit,
    output logic [imgWidth-1:0]  res_index,
    output logic                 res_timeout
);

    localparam int PixWidth = $clog2(pixelsPerImage) + 1;
    localparam int TmrWidth = $clog2(timeoutCycles) + 1;
    localparam int EntWidth = imgWidth + outWidth + 1;
    localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'(timeoutCycles - 1);

    seq_state_e           state_q;
    logic [imgWidth-1:0]  cnt_q;
    logic [imgWidth-1:0]  img_idx_q;
    logic [PixWidth-1:0]  pix_q;
    logic [TmrWidth-1:0]  timer_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_len_q;
    logic                 mem_ren_q;
    logic                 net_valid_q;
    logic [dataWidth-1:0] net_data_q;

    logic                 res_push;
    logic                 res_tmo;
    logic [outWidth-1:0]  push_digit;
    logic [EntWidth-1:0]  push_dat;
    logic [EntWidth-1:0]  pop_dat;
    logic                 fifo_full;

    // A real result wins over a timeout that expires in the same cycle.
    always_comb begin
        res_push = 1'b0;
        res_tmo  = 1'b0;
        if (state_q == WAIT_RES) begin
            if (net_out_valid) begin
                res_push = 1'b1;
            end else if (timer_q == TmrLast) begin
                res_push = 1'b1;
                res_tmo  = 1'b1;
            end
        end
        push_digit = res_tmo ? {outWidth{1'b0}} : net_out_data;
        push_dat   = {img_idx_q, push_digit, res_tmo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            img_idx_q   <= '0;
            pix_q       <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_len_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            net_valid_q <= 1'b0;
            net_data_q  <= '0;
        end else begin
            net_valid_q <= mem_valid;
            net_data_q  <= mem_data;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q     <= imgWidth'(clamp_count(32'(cfg_num_images), 32'(maxImages)));
                        img_idx_q <= '0;
                        err_len_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ARM;
                    end
                end
                // Nothing is outstanding here, so a free slot is simply "not full".
                ARM: begin
                    if (!fifo_full) begin
                        mem_ren_q <= 1'b1;
                        pix_q     <= '0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_valid) begin
                        if (mem_last) begin
                            if ((32'(pix_q) + 32'd1) != 32'(pixelsPerImage)) err_len_q <= 1'b1;
                            pix_q     <= '0;
                            mem_ren_q <= 1'b0;
                            timer_q   <= '0;
                            state_q   <= WAIT_RES;
                        end else begin
                            pix_q <= pix_q + 1'b1;
                        end
                    end
                end
                WAIT_RES: begin
                    timer_q <= timer_q + 1'b1;
                    if (res_push) begin
                        img_idx_q <= img_idx_q + 1'b1;
                        if ((img_idx_q + 1'b1) == cnt_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= ARM;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    nn_result_fifo #(
        .WIDTH (EntWidth),
        .DEPTH (resDepth)
    ) u_res_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (res_push),
        .push_dat_i (push_dat),
        .full_o     (fifo_full),
        .pop_vld_o  (res_valid),
        .pop_rdy_i  (res_ready),
        .pop_dat_o  (pop_dat)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_len     = err_len_q;
    assign mem_ren     = mem_ren_q;
    assign net_valid   = net_valid_q;
    assign net_data    = net_data_q;
    assign res_index   = pop_dat[EntWidth-1 -: imgWidth];
    assign res_digit   = pop_dat[outWidth:1];
    assign res_timeout = pop_dat[0];

endmodule

// File: doc/nn_frame_sequencer.md
Name: nn_frame_sequencer

Overview:
Synthesizable controller that streams a batch of images from the NN pixel memory into the NN core and buffers the classification results. It replaces bench-driven read-enable sequencing with an FSM and adds batch count, length checking and a result timeout. Results are drained through a valid/ready FIFO port. It sits between nn_memory and net in the top-level NN design.

Parameters:
dataWidth, 16, pixel/weight data width
outData, 10, number of output classes
outWidth, $clog2(outData), digit code width
pixelsPerImage, 784, expected beats per image, including the data_last beat
maxImages, 16, maximum batch size; imgWidth = $clog2(maxImages+1)
resDepth, 4, result FIFO depth (power of 2, >=2)
timeoutCycles, 4096, maximum cycles from data_last to net_out_valid

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a batch; ignored unless in IDLE
cfg_num_images  in  imgWidth  batch size, sampled on start; 0 or >maxImages is clamped to maxImages
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the batch completes
err_len  out  1  sticky: data_last arrived at the wrong beat count; cleared on start
mem_ren  out  1  read enable to nn_memory
mem_valid  in  1  pixel beat valid
mem_data  in  dataWidth  pixel beat
mem_last  in  1  last beat of the current image
net_valid  out  1  registered copy of mem_valid
net_data  out  dataWidth  registered copy of mem_data
net_out_valid  in  1  classification valid from net
net_out_data  in  outWidth  recognized digit
res_valid  out  1  result FIFO not empty
res_ready  in  1  consumer accepts the head entry
res_digit  out  outWidth  head entry digit (0 when timed out)
res_index  out  imgWidth  head entry image index, 0-based
res_timeout  out  1  head entry produced by timeout, not by net

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all counters=0; FIFO empty.
  - Outputs at reset: busy=0, done=0, err_len=0, mem_ren=0, net_valid=0, net_data=0, res_valid=0, res_digit=0, res_index=0, res_timeout=0.
- Forward path: net_valid/net_data are driven by flops from mem_valid/mem_data, giving a fixed 1-cycle latency. The flops load every cycle; nothing is dropped.
- FSM states: IDLE, ARM, FETCH, WAIT_RES, DONE.
  - IDLE: on start, latch the clamped count, clear img_idx, clear err_len, go to ARM.
  - ARM: if FIFO occupancy + outstanding < resDepth, go to FETCH; otherwise hold, so a result slot is always guaranteed before fetching.
  - FETCH: mem_ren=1 and the pixel counter increments on each mem_valid.
    - On mem_valid && mem_last: set err_len if the counter+1 != pixelsPerImage, clear the counter, drop mem_ren the next cycle, go to WAIT_RES, reset the timer.
    - mem_ren is registered and deasserts the cycle after the last beat. Any beats arriving in that cycle are still forwarded but are not counted.
  - WAIT_RES: the timer increments each cycle.
    - On net_out_valid: push {img_idx, net_out_data, 0}.
    - If the timer reaches timeoutCycles-1 first: push {img_idx, 0, 1}.
    - After either push, img_idx++. If img_idx+1 == latched count, go to DONE; else go to ARM.
  - DONE: done=1 for one cycle, then go to IDLE. busy=0 only in IDLE.
- net_out_valid outside WAIT_RES (a late result after a timeout) is discarded and is not pushed.
- start while busy is ignored.
- FIFO: resDepth entries, first-word fall-through. Read happens on res_valid && res_ready.
  - Simultaneous push and pop when full is legal; ARM guarantees a push never occurs when full without a pop.
  - Pointers wrap modulo resDepth, with an extra occupancy bit.
- Reset mid-batch: immediate return to reset values; FIFO contents are lost.

Decomposition:
- Package nn_seq_pkg: state enum (IDLE, ARM, FETCH, WAIT_RES, DONE), result entry struct {index, digit, timeout}, and the clamp helper function.
- One sub-module: nn_result_fifo (parametrised width/depth, FWFT, valid/ready read port, push/full write port).

Test Plan:
- Single image: cfg=1, memory supplies 784 beats with last on beat 784, net returns digit 7 twenty cycles later -> res_valid with index=0, digit=7, timeout=0. done pulses once, busy falls, err_len=0.
- Batch: cfg=3 with digits 3,1,4 -> three entries in order with index 0,1,2. mem_ren toggles off between images. net_valid follows mem_valid by exactly 1 cycle.
- Backpressure: resDepth=4, cfg=6, res_ready=0 -> after 4 entries the FSM holds in ARM with mem_ren=0. Raising res_ready resumes fetching, and all 6 entries are drained in order.
- Timeout: net never responds for image 1 of 2 -> an entry with index=1, digit=0, timeout=1 appears timeoutCycles after last. A late net_out_valid is discarded, and done still pulses.
- Length error: last on beat 500 -> err_len=1 stays high until the next start; the result is still collected. cfg=0 behaves as maxImages.
- Reset mid-FETCH: rst_n low for 3 cycles on beat 100 -> all outputs reach reset values asynchronously. start then runs a clean batch.
